// File: rtl/instruction_fetch_pkg.sv
// Purpose: shared definitions for the fetch stage and the units that
//          consume its state (hazard, decode).
// Contents: fetch FSM state encoding and the default reset PC / bubble word.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// Purpose: IF/ID pipeline register with load / hold / bubble control.
// Ports:
//   clk        - clock
//   reset      - asynchronous active-low reset, clears to a bubble
//   i_load     - capture i_instr / i_pc4 as a valid entry
//   i_bubble   - replace contents with a bubble (wins over i_load)
//   i_instr    - fetched instruction word
//   i_pc4      - PC+4 of the fetched word
//   o_instr    - registered instruction
//   o_pc4      - registered PC+4
//   o_valid    - 1 when o_instr is a real fetched word
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = instruction_fetch_pkg::DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Purpose: instruction fetch stage: PC register, fetch FSM, accepted-word
//          counter and the IF/ID pipeline register.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   imem_addr / imem_instr - combinational instruction memory interface
//   stall                 - hold PC and IF/ID
//   flush                 - bubble IF/ID on this edge
//   redirect_valid/target - taken branch/jump from a later stage
//   if_id_instr/pc4/valid - IF/ID register to decode
//   fault                 - sticky misaligned-redirect flag
//   fetch_count           - words accepted into IF/ID since reset
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BOOT  | one cycle after reset, PC = RESET_PC, IF/ID bubble
// ST_RUN   | normal fetch: redirect > stall > sequential
// ST_FAULT | misaligned redirect seen; everything frozen until reset
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // Low bits forced to zero so the PC can never hold an unaligned value.
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_pc4;
    logic         r_fault;
    logic [31:0]  r_fetch_count;
    logic         w_load;
    logic         w_bubble;
    logic         w_accept;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_RUN;
                w_bubble     = 1'b1;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_bubble = 1'b1;
                    if (redirect_target[1:0] != 2'b00) begin
                        w_next_state = ST_FAULT;
                    end else begin
                        w_next_pc = redirect_target;
                    end
                end else if (!stall) begin
                    w_next_pc = w_pc4;
                    w_load    = 1'b1;
                end
            end
            ST_FAULT: begin
                w_bubble = 1'b1;
            end
            default: begin
                w_next_state = ST_BOOT;
                w_next_pc    = PC_INIT;
                w_bubble     = 1'b1;
            end
        endcase
        if (flush) begin
            w_bubble = 1'b1;
        end
    end

    // A flushed word never reaches IF/ID, so it is not counted as accepted.
    assign w_accept = w_load & ~w_bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= PC_INIT;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_next_state == ST_FAULT) begin
                r_fault <= 1'b1;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_bubble (w_bubble),
        .i_instr  (imem_instr),
        .i_pc4    (w_pc4),
        .o_instr  (if_id_instr),
        .o_pc4    (if_id_pc4),
        .o_valid  (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_err;

    instruction_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    // Memory word at address A is {8'hC0, A[23:0]}.
    assign imem_instr = {8'hC0, imem_addr[23:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc4"}, if_id_pc4, pc4);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        #22;
        chk("rst.addr", imem_addr, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.fault", {31'b0, fault}, 32'h0);
        chk("rst.count", fetch_count, 32'h0);

        // Release away from the rising edge; BOOT then RUN.
        tick();
        reset = 1'b1;
        chk("boot.addr", imem_addr, 32'h0);
        tick();
        chk("run0.addr", imem_addr, 32'h0);
        chk("run0.valid", {31'b0, if_id_valid}, 32'h0);
        tick();
        chk("seq1.addr", imem_addr, 32'h4);
        chk_ifid("seq1", 32'hC000_0000, 32'h4, 1'b1);
        chk("seq1.count", fetch_count, 32'd1);
        tick();
        chk("seq2.addr", imem_addr, 32'h8);
        chk_ifid("seq2", 32'hC000_0004, 32'h8, 1'b1);
        chk("seq2.count", fetch_count, 32'd2);
        tick();
        chk("seq3.addr", imem_addr, 32'hC);
        tick();
        chk("seq4.addr", imem_addr, 32'h10);
        chk_ifid("seq4", 32'hC000_000C, 32'h10, 1'b1);
        chk("seq4.count", fetch_count, 32'd4);

        // Stall for 3 cycles at PC=0x10.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.addr", imem_addr, 32'h10);
            chk_ifid("stall", 32'hC000_000C, 32'h10, 1'b1);
            chk("stall.count", fetch_count, 32'd4);
        end

        // Redirect wins over stall.
        redirect_valid = 1'b1;
        redirect_target = 32'h98;
        tick();
        chk("redir.addr", imem_addr, 32'h98);
        chk_ifid("redir", 32'h0, 32'h0, 1'b0);
        chk("redir.count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        stall = 1'b0;
        tick();
        chk("redir_seq.addr", imem_addr, 32'h9C);
        chk_ifid("redir_seq", 32'hC000_0098, 32'h9C, 1'b1);
        chk("redir_seq.count", fetch_count, 32'd5);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_redir.addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        chk("wrap.addr", imem_addr, 32'h0);
        chk_ifid("wrap", 32'hC0FF_FFFC, 32'h0, 1'b1);
        chk("wrap.count", fetch_count, 32'd6);

        // Misaligned redirect -> FAULT, PC holds at 0.
        redirect_valid = 1'b1;
        redirect_target = 32'h22;
        tick();
        chk("fault.flag", {31'b0, fault}, 32'h1);
        chk("fault.addr", imem_addr, 32'h0);
        chk_ifid("fault", 32'h0, 32'h0, 1'b0);
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        chk("fault_hold.flag", {31'b0, fault}, 32'h1);
        chk("fault_hold.addr", imem_addr, 32'h0);
        chk_ifid("fault_hold", 32'h0, 32'h0, 1'b0);
        chk("fault_hold.count", fetch_count, 32'd6);

        // Asynchronous reset from FAULT takes effect before any edge.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst.fault", {31'b0, fault}, 32'h0);
        chk("async_rst.count", fetch_count, 32'h0);
        chk("async_rst.addr", imem_addr, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("restart.addr", imem_addr, 32'h4);
        chk_ifid("restart", 32'hC000_0000, 32'h4, 1'b1);
        chk("restart.count", fetch_count, 32'd1);

        // Flush in a sequential cycle: bubble, PC still advances.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.addr", imem_addr, 32'h8);
        chk_ifid("flush", 32'h0, 32'h0, 1'b0);
        tick();
        chk("post_flush.addr", imem_addr, 32'hC);
        chk_ifid("post_flush", 32'hC000_0008, 32'hC, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
